data_hold_fifo: RTL and testbench

DATA_HOLD_FIFO -- requirements
Module: data_hold_fifo

---
 rtl/serdes_pkg.sv | 11 +
 rtl/hold_ram.sv | 24 ++
 rtl/data_hold_fifo.sv | 103 ++++++++++
 tb/tb_data_hold_fifo.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/serdes_pkg.sv
// rtl/serdes_pkg.sv - shared defaults and elaboration helpers for the hold FIFO
package serdes_pkg;

   localparam int SERDES_DATA_W = 8;
   localparam int SERDES_DEPTH  = 4;

   function automatic bit is_pow2(input int n);
      return (n > 0) && ((n & (n - 1)) == 0);
   endfunction

endpackage

// File: rtl/hold_ram.sv
// rtl/hold_ram.sv - DATA_W x DEPTH storage, one write port, asynchronous read, no reset
module hold_ram #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 4
) (
   input  logic                     clk,
   input  logic                     we,
   input  logic [$clog2(DEPTH)-1:0] waddr,
   input  logic [DATA_W-1:0]        wdata,
   input  logic [$clog2(DEPTH)-1:0] raddr,
   output logic [DATA_W-1:0]        rdata
);

   logic [DATA_W-1:0] mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[waddr] <= wdata;
      end
   end

   assign rdata = mem_q[raddr];

endmodule

// File: rtl/data_hold_fifo.sv
// rtl/data_hold_fifo.sv - first-word-fall-through FIFO that holds the last popped word
// when empty, with sticky overflow on dropped writes and a synchronous flush.
module data_hold_fifo
   import serdes_pkg::*;
#(
   parameter int DATA_W = SERDES_DATA_W,
   parameter int DEPTH  = SERDES_DEPTH
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [DATA_W-1:0]          data_in,
   input  logic                       data_en,
   output logic                       in_ready,
   output logic [DATA_W-1:0]          data_out,
   output logic                       out_valid,
   input  logic                       out_ready,
   input  logic                       flush,
   output logic [$clog2(DEPTH+1)-1:0] level,
   output logic                       overflow
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = $clog2(DEPTH + 1);
   localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

   if (!is_pow2(DEPTH) || DEPTH < 2 || DEPTH > 64) begin : g_bad_depth
      $error("data_hold_fifo: DEPTH must be a power of two in 2..64");
   end
   if (DATA_W < 1 || DATA_W > 64) begin : g_bad_width
      $error("data_hold_fifo: DATA_W must be in 1..64");
   end

   logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [LW-1:0]     level_q, level_d;
   logic              overflow_q, overflow_d;
   logic [DATA_W-1:0] hold_q, hold_d;
   logic [DATA_W-1:0] head_word;
   logic              push, pop, drop;

   always_comb begin
      in_ready   = (level_q != FULL_LVL);
      out_valid  = (level_q != '0);
      push       = data_en & in_ready;
      drop       = data_en & ~in_ready;
      pop        = out_valid & out_ready;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      level_d    = level_q;
      overflow_d = overflow_q;
      hold_d     = hold_q;

      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      // The popped head is captured so data_out can keep showing it once empty.
      if (pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
         hold_d   = head_word;
      end
      if (push && !pop)      level_d = level_q + 1'b1;
      else if (pop && !push) level_d = level_q - 1'b1;
      if (drop) overflow_d = 1'b1;

      if (flush) begin
         wr_ptr_d   = '0;
         rd_ptr_d   = '0;
         level_d    = '0;
         overflow_d = 1'b0;
         hold_d     = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         level_q    <= '0;
         overflow_q <= 1'b0;
         hold_q     <= '0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         level_q    <= level_d;
         overflow_q <= overflow_d;
         hold_q     <= hold_d;
      end
   end

   hold_ram #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_ram (
      .clk   (clk),
      .we    (push & ~flush),
      .waddr (wr_ptr_q),
      .wdata (data_in),
      .raddr (rd_ptr_q),
      .rdata (head_word)
   );

   assign data_out = out_valid ? head_word : hold_q;
   assign level    = level_q;
   assign overflow = overflow_q;

endmodule

// File: tb/tb_data_hold_fifo.sv
// tb/tb_data_hold_fifo.sv - directed self-checking bench for data_hold_fifo
module tb_data_hold_fifo;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   // default instance: DATA_W=8, DEPTH=4
   logic [7:0] a_in = '0, a_out;
   logic       a_en = 0, a_rdy = 0, a_fl = 0, a_ir, a_ov, a_ovf;
   logic [2:0] a_lvl;

   // sweep instance: DATA_W=1, DEPTH=2
   logic       b_in = 0, b_out;
   logic       b_en = 0, b_rdy = 0, b_fl = 0, b_ir, b_ov, b_ovf;
   logic [1:0] b_lvl;

   // sweep instance: DATA_W=32, DEPTH=16
   logic [31:0] c_in = '0, c_out;
   logic        c_en = 0, c_rdy = 0, c_fl = 0, c_ir, c_ov, c_ovf;
   logic [4:0]  c_lvl;

   data_hold_fifo u_a (
      .clk(clk), .rst_n(rst_n), .data_in(a_in), .data_en(a_en), .in_ready(a_ir),
      .data_out(a_out), .out_valid(a_ov), .out_ready(a_rdy), .flush(a_fl),
      .level(a_lvl), .overflow(a_ovf));

   data_hold_fifo #(.DATA_W(1), .DEPTH(2)) u_b (
      .clk(clk), .rst_n(rst_n), .data_in(b_in), .data_en(b_en), .in_ready(b_ir),
      .data_out(b_out), .out_valid(b_ov), .out_ready(b_rdy), .flush(b_fl),
      .level(b_lvl), .overflow(b_ovf));

   data_hold_fifo #(.DATA_W(32), .DEPTH(16)) u_c (
      .clk(clk), .rst_n(rst_n), .data_in(c_in), .data_en(c_en), .in_ready(c_ir),
      .data_out(c_out), .out_valid(c_ov), .out_ready(c_rdy), .flush(c_fl),
      .level(c_lvl), .overflow(c_ovf));

   int n_pass = 0;
   int n_total = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #2;
      chk("rst_level", a_lvl, 0);
      chk("rst_valid", a_ov, 0);
      chk("rst_ready", a_ir, 1);
      chk("rst_ovf", a_ovf, 0);
      chk("rst_dout", a_out, 0);
      cyc();
      rst_n = 1'b1;

      // reset/hold
      a_in = 8'hA5; a_en = 1;
      cyc();
      a_en = 0;
      chk("hold_lat_valid", a_ov, 1);
      chk("hold_lat_dout", a_out, 8'hA5);
      chk("hold_lat_level", a_lvl, 1);
      a_rdy = 1;
      cyc();
      a_rdy = 0;
      for (int i = 0; i < 3; i++) begin
         cyc();
         chk("hold_idle_valid", a_ov, 0);
         chk("hold_idle_dout", a_out, 8'hA5);
         chk("hold_idle_level", a_lvl, 0);
      end

      // fill and overflow
      a_en = 1;
      for (int i = 1; i <= 4; i++) begin
         a_in = 8'(i);
         cyc();
         chk("fill_level", a_lvl, 64'(i));
      end
      chk("fill_ready", a_ir, 0);
      chk("fill_ovf_pre", a_ovf, 0);
      a_in = 8'h05;
      cyc();
      a_en = 0;
      chk("fill_drop_level", a_lvl, 4);
      chk("fill_drop_ovf", a_ovf, 1);
      a_rdy = 1;
      for (int i = 1; i <= 4; i++) begin
         chk("fill_pop_dout", a_out, 64'(i));
         cyc();
      end
      a_rdy = 0;
      chk("fill_empty_level", a_lvl, 0);
      chk("fill_empty_hold", a_out, 8'h04);
      chk("fill_ovf_sticky", a_ovf, 1);
      a_fl = 1;
      cyc();
      a_fl = 0;
      chk("flush_ovf", a_ovf, 0);
      chk("flush_dout", a_out, 0);

      // push into empty with out_ready high must not pop it
      a_in = 8'h10; a_en = 1; a_rdy = 1;
      cyc();
      chk("empty_push_level", a_lvl, 1);
      chk("empty_push_dout", a_out, 8'h10);
      a_rdy = 0; a_in = 8'h11;
      cyc();
      chk("conc_pre_level", a_lvl, 2);

      // concurrent push/pop across pointer wrap
      a_rdy = 1;
      for (int k = 0; k < 16; k++) begin
         a_in = 8'(8'h12 + k);
         chk("conc_dout", a_out, 64'(8'h10 + k));
         cyc();
         chk("conc_level", a_lvl, 2);
      end
      a_rdy = 0;
      a_in = 8'h22;
      cyc();
      a_in = 8'h23;
      cyc();
      chk("full_level", a_lvl, 4);

      // push+pop while full
      a_in = 8'hEE; a_rdy = 1;
      chk("full_pp_head", a_out, 8'h20);
      cyc();
      a_en = 0;
      chk("full_pp_level", a_lvl, 3);
      chk("full_pp_ovf", a_ovf, 1);
      for (int i = 0; i < 3; i++) begin
         chk("full_pp_drain", a_out, 64'(8'h21 + i));
         cyc();
      end
      a_rdy = 0;
      chk("full_pp_empty", a_lvl, 0);
      chk("full_pp_hold", a_out, 8'h23);

      // flush priority at level 3 with overflow set
      a_en = 1;
      for (int i = 0; i < 3; i++) begin
         a_in = 8'(8'h31 + i);
         cyc();
      end
      chk("flp_pre_level", a_lvl, 3);
      chk("flp_pre_ovf", a_ovf, 1);
      a_in = 8'h99; a_rdy = 1; a_fl = 1;
      cyc();
      a_fl = 0; a_en = 0; a_rdy = 0;
      chk("flp_level", a_lvl, 0);
      chk("flp_ovf", a_ovf, 0);
      chk("flp_dout", a_out, 0);
      chk("flp_valid", a_ov, 0);

      // asynchronous reset mid-stream
      a_en = 1;
      for (int i = 0; i < 5; i++) begin
         a_in = 8'(8'h41 + i);
         cyc();
      end
      a_en = 0; a_rdy = 1;
      cyc();
      cyc();
      a_rdy = 0;
      chk("arst_pre_level", a_lvl, 2);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("arst_level", a_lvl, 0);
      chk("arst_valid", a_ov, 0);
      chk("arst_ready", a_ir, 1);
      chk("arst_ovf", a_ovf, 0);
      chk("arst_dout", a_out, 0);
      cyc();
      rst_n = 1'b1;
      a_in = 8'h77; a_en = 1;
      cyc();
      a_en = 0;
      chk("arst_push_level", a_lvl, 1);
      chk("arst_push_dout", a_out, 8'h77);

      // sweep DATA_W=1, DEPTH=2
      b_en = 1; b_in = 1;
      cyc();
      b_in = 0;
      cyc();
      chk("b_full_level", b_lvl, 2);
      chk("b_full_ready", b_ir, 0);
      chk("b_ovf_pre", b_ovf, 0);
      b_in = 1;
      cyc();
      b_en = 0;
      chk("b_drop_level", b_lvl, 2);
      chk("b_drop_ovf", b_ovf, 1);
      b_rdy = 1;
      chk("b_pop0", b_out, 1);
      cyc();
      chk("b_pop1", b_out, 0);
      cyc();
      b_rdy = 0;
      chk("b_empty_level", b_lvl, 0);
      chk("b_empty_valid", b_ov, 0);

      // sweep DATA_W=32, DEPTH=16
      c_en = 1;
      for (int i = 0; i < 16; i++) begin
         c_in = 32'hC0DE_0000 + 32'(i);
         cyc();
      end
      chk("c_full_level", c_lvl, 16);
      chk("c_full_ready", c_ir, 0);
      chk("c_ovf_pre", c_ovf, 0);
      c_in = 32'hDEAD_BEEF;
      cyc();
      c_en = 0;
      chk("c_drop_level", c_lvl, 16);
      chk("c_drop_ovf", c_ovf, 1);
      c_rdy = 1;
      for (int i = 0; i < 16; i++) begin
         chk("c_pop", c_out, 64'(32'hC0DE_0000 + 32'(i)));
         cyc();
      end
      c_rdy = 0;
      chk("c_empty_level", c_lvl, 0);
      chk("c_empty_hold", c_out, 32'hC0DE_000F);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
